// File: rtl/dma_pkg.sv
// Shared definitions for data-memory bus initiators: copy FSM states, word size and
// data-bus region bases.
package dma_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRead,
        StWrite,
        StDone,
        StErr
    } dma_state_e;

    localparam int unsigned WORD_BYTES = 4;

    localparam logic [31:0] GLOBAL_BASE = 32'h1001_0000;
    localparam logic [31:0] STACK_BASE  = 32'h7fff_f000;
    localparam logic [31:0] PERI_BASE   = 32'h4000_0000;

    function automatic logic misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dma_copy_master.sv
// Word-copy bus initiator: after a start pulse, arbitrates for the data bus and copies
// word_cnt aligned words from src to dst, one read then one write per word.
module dma_copy_master
    import dma_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      err_addr,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic             rd,
    output logic             wr,
    output logic [31:0]      addr,
    output logic [31:0]      wdata,
    input  logic [31:0]      rdata,
    input  logic             accessable
);

    dma_state_e       state_q;
    logic [31:0]      cur_src_q;
    logic [31:0]      cur_dst_q;
    logic [CNT_W-1:0] remain_q;
    logic [31:0]      buf_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [31:0]      err_addr_q;
    logic             bus_req_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cur_src_q  <= '0;
            cur_dst_q  <= '0;
            remain_q   <= '0;
            buf_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            bus_req_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != StIdle) begin
                state_q   <= StIdle;
                busy_q    <= 1'b0;
                bus_req_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            cur_src_q <= src_addr;
                            cur_dst_q <= dst_addr;
                            remain_q  <= word_cnt;
                            err_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            // Source alignment is reported ahead of destination alignment.
                            if (word_cnt == '0) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else if (misaligned(src_addr)) begin
                                state_q    <= StErr;
                                err_q      <= 1'b1;
                                err_addr_q <= src_addr;
                            end else if (misaligned(dst_addr)) begin
                                state_q    <= StErr;
                                err_q      <= 1'b1;
                                err_addr_q <= dst_addr;
                            end else begin
                                state_q   <= StReq;
                                bus_req_q <= 1'b1;
                            end
                        end
                    end
                    StReq: begin
                        if (bus_gnt) state_q <= StRead;
                    end
                    StRead: begin
                        if (bus_gnt) begin
                            if (accessable) begin
                                buf_q   <= rdata;
                                state_q <= StWrite;
                            end else begin
                                state_q    <= StErr;
                                err_q      <= 1'b1;
                                err_addr_q <= cur_src_q;
                                bus_req_q  <= 1'b0;
                            end
                        end
                    end
                    StWrite: begin
                        if (bus_gnt) begin
                            if (!accessable) begin
                                state_q    <= StErr;
                                err_q      <= 1'b1;
                                err_addr_q <= cur_dst_q;
                                bus_req_q  <= 1'b0;
                            end else begin
                                cur_src_q <= cur_src_q + 32'(WORD_BYTES);
                                cur_dst_q <= cur_dst_q + 32'(WORD_BYTES);
                                remain_q  <= remain_q - CNT_W'(1);
                                if (remain_q == CNT_W'(1)) begin
                                    state_q   <= StDone;
                                    done_q    <= 1'b1;
                                    bus_req_q <= 1'b0;
                                end else begin
                                    state_q <= StRead;
                                end
                            end
                        end
                    end
                    StDone, StErr: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        bus_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Bus strobes follow only the state and the grant; never rdata or accessable.
    always_comb begin
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        case (state_q)
            StRead: begin
                rd   = bus_gnt;
                addr = cur_src_q;
            end
            StWrite: begin
                wr    = bus_gnt;
                addr  = cur_dst_q;
                wdata = buf_q;
            end
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;
    assign bus_req  = bus_req_q;

endmodule

// File: tb/tb_dma_copy_master.sv
// Directed bench for dma_copy_master with a 16-word data memory at GLOBAL_BASE.
module tb_dma_copy_master;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_cnt;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] err_addr;
    logic        bus_req;
    logic        bus_gnt;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        accessable;

    always #5 clk = ~clk;

    dma_copy_master #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_cnt   (word_cnt),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_addr   (err_addr),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .accessable (accessable)
    );

    // Responder: 16 words at GLOBAL_BASE, aligned accesses only.
    logic [31:0] mem [16];
    logic [31:0] off;
    assign off        = addr - GLOBAL_BASE;
    assign accessable = (off < 32'd64) && (addr[1:0] == 2'b00);
    assign rdata      = accessable ? mem[off[5:2]] : 32'hDEAD_BEEF;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic init_mem();
        for (int i = 0; i < 16; i++) mem[i] = pat(i);
    endtask

    // Per-run schedule and observations.
    int          gnt_lo, gnt_hi, abort_cyc, restart_cyc;
    logic [31:0] hold_addr;
    int          done_cyc, rd_n, wr_n, commit_n, breq_n, hold_bad;
    logic        err_at1;

    task automatic sample_bus();
        if (rd) rd_n++;
        if (wr) begin
            wr_n++;
            if (accessable) begin
                mem[off[5:2]] = wdata;
                commit_n++;
            end
        end
        if (!bus_gnt && (rd || wr || addr != hold_addr)) hold_bad++;
    endtask

    // Start at cycle 0; inputs change #1 after posedge, outputs sampled at negedge.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input int max_cyc);
        logic finished;
        finished = 1'b0;
        @(posedge clk);
        #1;
        src_addr = s;
        dst_addr = d;
        word_cnt = n;
        start    = 1'b1;
        bus_gnt  = 1'b1;
        abort    = 1'b0;
        done_cyc = 0; rd_n = 0; wr_n = 0; commit_n = 0; breq_n = 0; hold_bad = 0;
        err_at1  = 1'b0;
        #4;
        sample_bus();
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk);
            #1;
            start = (k == restart_cyc);
            if (k == restart_cyc) src_addr = GLOBAL_BASE + 32'd1;
            bus_gnt = !(k >= gnt_lo && k <= gnt_hi);
            abort   = (k == abort_cyc);
            #4;
            if (k == 1) err_at1 = err;
            sample_bus();
            if (done) done_cyc = k;
            if (bus_req) breq_n++;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        start   = 1'b0;
        abort   = 1'b0;
        bus_gnt = 1'b1;
        if (!finished) check("timeout", 32'd0, 32'd1);
        gnt_lo = -1; gnt_hi = -1; abort_cyc = -1; restart_cyc = -1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; bus_gnt = 1'b1;
        src_addr = '0; dst_addr = '0; word_cnt = '0;
        gnt_lo = -1; gnt_hi = -1; abort_cyc = -1; restart_cyc = -1;
        hold_addr = '0;
        init_mem();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst err", 32'(err), 0);
        check("rst bus_req", 32'(bus_req), 0);
        check("rst rd", 32'(rd), 0);
        check("rst wr", 32'(wr), 0);
        check("rst addr", addr, 0);
        check("rst wdata", wdata, 0);
        check("rst err_addr", err_addr, 0);
        reset_n = 1'b1;

        // Four-word copy with continuous grant.
        init_mem();
        run(GLOBAL_BASE, GLOBAL_BASE + 32'h20, 16'd4, 40);
        check("c4 done_cyc", 32'(done_cyc), 10);
        check("c4 err", 32'(err), 0);
        check("c4 rd_n", 32'(rd_n), 4);
        check("c4 wr_n", 32'(wr_n), 4);
        check("c4 bus_req cycles", 32'(breq_n), 9);
        for (int i = 0; i < 4; i++) check($sformatf("c4 mem[%0d]", 8 + i), mem[8 + i], pat(i));
        check("c4 mem[12]", mem[12], pat(12));

        // Zero-length transfer.
        run(GLOBAL_BASE, GLOBAL_BASE + 32'h20, 16'd0, 20);
        check("c0 done_cyc", 32'(done_cyc), 1);
        check("c0 rd_n", 32'(rd_n), 0);
        check("c0 wr_n", 32'(wr_n), 0);
        check("c0 bus_req cycles", 32'(breq_n), 0);

        // Misaligned source.
        run(GLOBAL_BASE + 32'h2, GLOBAL_BASE + 32'h20, 16'd1, 20);
        check("ms err", 32'(err), 1);
        check("ms err_addr", err_addr, 32'h1001_0002);
        check("ms rd_n", 32'(rd_n), 0);
        check("ms bus_req cycles", 32'(breq_n), 0);
        check("ms done_cyc", 32'(done_cyc), 0);

        // Second write falls off the end of the memory.
        init_mem();
        run(GLOBAL_BASE, GLOBAL_BASE + 32'h3C, 16'd2, 40);
        check("ov err cleared", 32'(err_at1), 0);
        check("ov mem[15]", mem[15], pat(0));
        check("ov commits", 32'(commit_n), 1);
        check("ov err", 32'(err), 1);
        check("ov err_addr", err_addr, 32'h1001_0040);
        check("ov done_cyc", 32'(done_cyc), 0);

        // Grant withdrawn for three cycles during the second write.
        init_mem();
        gnt_lo = 5; gnt_hi = 7; hold_addr = GLOBAL_BASE + 32'h14;
        run(GLOBAL_BASE, GLOBAL_BASE + 32'h10, 16'd3, 40);
        check("gd hold violations", 32'(hold_bad), 0);
        check("gd done_cyc", 32'(done_cyc), 11);
        check("gd wr_n", 32'(wr_n), 3);
        check("gd err", 32'(err), 0);
        for (int i = 0; i < 3; i++) check($sformatf("gd mem[%0d]", 4 + i), mem[4 + i], pat(i));

        // Abort in the read of word 2 of 5.
        init_mem();
        abort_cyc = 6;
        run(GLOBAL_BASE, GLOBAL_BASE + 32'h20, 16'd5, 40);
        check("ab commits", 32'(commit_n), 2);
        check("ab mem[8]", mem[8], pat(0));
        check("ab mem[9]", mem[9], pat(1));
        check("ab mem[10]", mem[10], pat(10));
        check("ab done_cyc", 32'(done_cyc), 0);
        check("ab err", 32'(err), 0);
        check("ab bus_req", 32'(bus_req), 0);

        // A start while busy must be ignored.
        init_mem();
        restart_cyc = 2;
        run(GLOBAL_BASE, GLOBAL_BASE + 32'h28, 16'd2, 40);
        check("ib done_cyc", 32'(done_cyc), 6);
        check("ib err", 32'(err), 0);
        check("ib mem[10]", mem[10], pat(0));
        check("ib mem[11]", mem[11], pat(1));

        // Fresh single-word copy.
        run(GLOBAL_BASE + 32'h3C, GLOBAL_BASE, 16'd1, 20);
        check("fs done_cyc", 32'(done_cyc), 4);
        check("fs mem[0]", mem[0], pat(15));
        check("fs err", 32'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
